decode_vec_stage: RTL and testbench
===================================

DECODE_VEC_STAGE -- requirements
Module: decode_vec_stage

Interface
REQ-001 Parameter LANES, default 3: vector lanes per register.
REQ-002 Parameter WIDTH, default 18: bits per lane.
REQ-003 Parameter NREGS, default 16, legal 2..16: registers; AW=$clog2(NREGS).
REQ-004 Parameter IMMW, default 10: immediate field width, taken from Instr[27:28-IMMW].
REQ-005 Ports SHALL be exactly as listed below:
- clk  in  1  sole clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode-stage instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- Instr  in  28  instruction word.
- RegSrc  in  2  [0]: ra1 = NREGS-1; [1]: ra2 from Instr[7:4], else Instr[11:8].
- ImmSrcD  in  1  0 = zero-extend, 1 = sign-extend the immediate.
- RegWriteD, MemToRegD  in  1 each  control bits carried to execute.
- flushE  in  1  kill the execute-side register.
- out_valid  out  1  execute register holds a live instruction.
- out_ready  in  1  execute consumes the instruction.
- RegWriteW  in  1  writeback enable.
- wa3w  in  AW  writeback address.
- wd3  in  LANES x WIDTH  writeback data.
- lane_mask_w  in  LANES  per-lane write enable.
- rd1E, rd2E, ExtImmE  out  LANES x WIDTH  registered operands and immediate.
- ra1E, ra2E, wa3E  out  AW each  registered addresses.
- RegWriteE, MemToRegE  out  1 each  registered control bits.
- stallD  out  1  load-use hazard is active this cycle.

Function
REQ-006 Register fields SHALL use the low AW bits of Instr[3:0], Instr[7:4], Instr[11:8] and Instr[15:12]; wa3D SHALL come from Instr[15:12].
REQ-007 ra1 SHALL be NREGS-1 when RegSrc[0]=1, else Instr[3:0]; ra2 SHALL be Instr[7:4] when RegSrc[1]=1, else Instr[11:8].
REQ-008 The register file SHALL hold NREGS x LANES x WIDTH bits and SHALL write lane l of wa3w on the rising clk edge when RegWriteW && lane_mask_w[l].
REQ-009 Reads SHALL be combinational with write bypass: for lane l, if RegWriteW && lane_mask_w[l] && wa3w==ra, that lane returns wd3[l]; otherwise it returns the stored value.
REQ-010 The immediate SHALL be extended to WIDTH according to ImmSrcD and replicated to every lane.
REQ-011 stallD SHALL equal out_valid && MemToRegE && RegWriteE && (wa3E==ra1 || wa3E==ra2).
REQ-012 in_ready SHALL equal !stallD && (!out_valid || out_ready).
REQ-013 On in_valid && in_ready, all E registers SHALL load the decoded values and out_valid SHALL be 1 the next cycle; latency is 1 cycle.
REQ-014 If out_valid && out_ready occurs with no accept, out_valid SHALL be 0 the next cycle. A stall therefore inserts exactly one bubble.
REQ-015 While out_valid && !out_ready, all E registers SHALL hold their values.
REQ-016 flushE SHALL override every other condition: next cycle out_valid=0. An instruction accepted in the same cycle is consumed and discarded.
REQ-017 While out_valid=0, the data outputs are don't-care. RegWriteE and MemToRegE SHALL be 0.

Reset
REQ-018 While RST=0: out_valid=0, all E registers=0, every register-file entry=0, effective immediately without waiting for a clock edge.
REQ-019 Reset SHALL abort an in-flight instruction. The first accept SHALL be possible on the first clk edge after RST rises.

Structure
REQ-020 Package decode_vec_pkg SHALL hold the default parameters, the instruction field positions and the ImmSrc encoding constants.
REQ-021 The register file plus bypass SHALL be one sub-module, regfile_vec_bypass. The pipeline register and the hazard logic SHALL be in decode_vec_stage.

Verification
REQ-022 Reset, write then read:
- Stimulus: RST pulse; write wa3w=3, wd3={18'h1,18'h2,18'h3}, mask 111; next decode with Instr[3:0]=3.
- Required response: rd1E={1,2,3} one cycle after accept.
REQ-023 Bypass with lane mask:
- Stimulus: write to r5 with mask 010 in the same cycle a decode reads r5 (old value 0), wd3 all 18'h3FFFF.
- Required response: rd1E={0,3FFFF,0}.
REQ-024 Immediate extension:
- Stimulus: Instr[27:18]=10'h200, with ImmSrcD=1 and then ImmSrcD=0.
- Required response: ExtImmE lanes = 18'h3FE00 for ImmSrcD=1, 18'h00200 for ImmSrcD=0.
REQ-025 Load-use hazard:
- Stimulus: a load with Rd=4 in E, out_ready=1; next instruction reads ra2=4.
- Required response: stallD=1 and in_ready=0 for one cycle, a bubble appears (out_valid=0), then the instruction is accepted.
REQ-026 Backpressure and flush:
- Stimulus: hold out_ready=0 for 3 cycles; then assert flushE together with in_valid.
- Required response: E outputs stable during the hold; after the flush, out_valid=0 and the incoming instruction is discarded.
REQ-027 RegSrc muxing and mid-operation reset:
- Stimulus: RegSrc=2'b11 with NREGS=8, then RST=0 mid-stream.
- Required response: ra1E=7 and ra2E=Instr[6:4]; when RST drops, out_valid falls to 0 asynchronously and all registers read 0 afterwards.

Source files
------------

// File: rtl/decode_vec_pkg.sv
// Shared defaults, instruction field positions and immediate-extension encodings
// for the vector decode stage.
package decode_vec_pkg;

  localparam int LANES_DEF = 3;
  localparam int WIDTH_DEF = 18;
  localparam int NREGS_DEF = 16;
  localparam int IMMW_DEF  = 10;

  localparam int INSTR_W     = 28;
  localparam int RA1_LSB     = 0;
  localparam int RA2_ALT_LSB = 4;
  localparam int RA2_LSB     = 8;
  localparam int WA3_LSB     = 12;
  localparam int IMM_MSB     = 27;

  localparam logic IMM_ZERO = 1'b0;
  localparam logic IMM_SIGN = 1'b1;

endpackage

// File: rtl/regfile_vec_bypass.sv
// Lane-masked vector register file, two combinational read ports with write bypass.
// Latency: reads 0 cycles, writes land on the next edge; no backpressure.
module regfile_vec_bypass
  import decode_vec_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [AW-1:0]                wa,
  input  logic [LANES-1:0]             lane_mask,
  input  logic [LANES-1:0][WIDTH-1:0]  wd,
  input  logic [AW-1:0]                ra1,
  input  logic [AW-1:0]                ra2,
  output logic [LANES-1:0][WIDTH-1:0]  rd1,
  output logic [LANES-1:0][WIDTH-1:0]  rd2
);

  logic [LANES-1:0][WIDTH-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else if (we) begin
      for (int l = 0; l < LANES; l++)
        if (lane_mask[l]) mem[wa][l] <= wd[l];
    end
  end

  // A lane being written this cycle is forwarded so decode never sees stale data.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int l = 0; l < LANES; l++) begin
      rd1[l] = (we && lane_mask[l] && wa == ra1) ? wd[l] : mem[ra1][l];
      rd2[l] = (we && lane_mask[l] && wa == ra2) ? wd[l] : mem[ra2][l];
    end
  end

endmodule

// File: rtl/decode_vec_stage.sv
// Vector decode stage: operand read, immediate extend, load-use stall, D->E register.
// Latency 1 cycle; E register holds while out_ready is low, flushE empties it.
module decode_vec_stage
  import decode_vec_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int IMMW  = IMMW_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTR_W-1:0]           Instr,
  input  logic [1:0]                   RegSrc,
  input  logic                         ImmSrcD,
  input  logic                         RegWriteD,
  input  logic                         MemToRegD,
  input  logic                         flushE,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         RegWriteW,
  input  logic [AW-1:0]                wa3w,
  input  logic [LANES-1:0][WIDTH-1:0]  wd3,
  input  logic [LANES-1:0]             lane_mask_w,
  output logic [LANES-1:0][WIDTH-1:0]  rd1E,
  output logic [LANES-1:0][WIDTH-1:0]  rd2E,
  output logic [LANES-1:0][WIDTH-1:0]  ExtImmE,
  output logic [AW-1:0]                ra1E,
  output logic [AW-1:0]                ra2E,
  output logic [AW-1:0]                wa3E,
  output logic                         RegWriteE,
  output logic                         MemToRegE,
  output logic                         stallD
);

  logic [AW-1:0]               ra1, ra2, wa3d;
  logic [IMMW-1:0]             imm;
  logic [WIDTH-1:0]            ext;
  logic [LANES-1:0][WIDTH-1:0] rd1, rd2;
  logic                        accept;
  logic                        unused_instr;

  assign ra1  = RegSrc[0] ? AW'(NREGS - 1) : Instr[RA1_LSB +: AW];
  assign ra2  = RegSrc[1] ? Instr[RA2_ALT_LSB +: AW] : Instr[RA2_LSB +: AW];
  assign wa3d = Instr[WA3_LSB +: AW];
  assign imm  = Instr[IMM_MSB -: IMMW];
  assign ext  = {{(WIDTH-IMMW){(ImmSrcD == IMM_SIGN) & imm[IMMW-1]}}, imm};
  assign unused_instr = ^Instr;

  regfile_vec_bypass #(
    .LANES(LANES), .WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)
  ) u_rf (
    .clk       (clk),
    .rst_n     (RST),
    .we        (RegWriteW),
    .wa        (wa3w),
    .lane_mask (lane_mask_w),
    .wd        (wd3),
    .ra1       (ra1),
    .ra2       (ra2),
    .rd1       (rd1),
    .rd2       (rd2)
  );

  // Load result is not available until after execute, so a dependent reader must wait.
  assign stallD   = out_valid && MemToRegE && RegWriteE && (wa3E == ra1 || wa3E == ra2);
  assign in_ready = !stallD && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      out_valid <= 1'b0;
      rd1E      <= '0;
      rd2E      <= '0;
      ExtImmE   <= '0;
      ra1E      <= '0;
      ra2E      <= '0;
      wa3E      <= '0;
      RegWriteE <= 1'b0;
      MemToRegE <= 1'b0;
    end else if (flushE) begin
      out_valid <= 1'b0;
      RegWriteE <= 1'b0;
      MemToRegE <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      rd1E      <= rd1;
      rd2E      <= rd2;
      ExtImmE   <= {LANES{ext}};
      ra1E      <= ra1;
      ra2E      <= ra2;
      wa3E      <= wa3d;
      RegWriteE <= RegWriteD;
      MemToRegE <= MemToRegD;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      RegWriteE <= 1'b0;
      MemToRegE <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_vec_stage.sv
// Directed and randomized checks of decode_vec_stage against a transaction-level model.
module tb_decode_vec_stage;

  localparam int LANES = 3;
  localparam int WIDTH = 18;
  localparam int NREGS = 8;
  localparam int IMMW  = 10;
  localparam int AW    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic RST = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [27:0] Instr = '0;
  logic [1:0] RegSrc = '0;
  logic ImmSrcD = 1'b0, RegWriteD = 1'b0, MemToRegD = 1'b0, flushE = 1'b0;
  logic out_valid, out_ready = 1'b1;
  logic RegWriteW = 1'b0;
  logic [AW-1:0] wa3w = '0;
  logic [LANES-1:0][WIDTH-1:0] wd3 = '0;
  logic [LANES-1:0] lane_mask_w = '0;
  logic [LANES-1:0][WIDTH-1:0] rd1E, rd2E, ExtImmE;
  logic [AW-1:0] ra1E, ra2E, wa3E;
  logic RegWriteE, MemToRegE, stallD;

  decode_vec_stage #(.LANES(LANES), .WIDTH(WIDTH), .NREGS(NREGS), .IMMW(IMMW)) dut (
    .clk(clk), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .Instr(Instr),
    .RegSrc(RegSrc), .ImmSrcD(ImmSrcD), .RegWriteD(RegWriteD), .MemToRegD(MemToRegD),
    .flushE(flushE), .out_valid(out_valid), .out_ready(out_ready), .RegWriteW(RegWriteW),
    .wa3w(wa3w), .wd3(wd3), .lane_mask_w(lane_mask_w), .rd1E(rd1E), .rd2E(rd2E),
    .ExtImmE(ExtImmE), .ra1E(ra1E), .ra2E(ra2E), .wa3E(wa3E), .RegWriteE(RegWriteE),
    .MemToRegE(MemToRegE), .stallD(stallD)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural register contents and the instruction sitting in execute.
  logic [LANES-1:0][WIDTH-1:0] mreg [NREGS];
  bit mv, mrw, mm2r;
  int mra1, mra2, mwa;
  logic [LANES-1:0][WIDTH-1:0] mrd1, mrd2, mimm;

  function automatic int fld(input int lsb);
    return int'((Instr >> lsb) & 28'hF) % NREGS;
  endfunction

  function automatic int m_ra1();
    return RegSrc[0] ? NREGS - 1 : fld(0);
  endfunction

  function automatic int m_ra2();
    return RegSrc[1] ? fld(4) : fld(8);
  endfunction

  function automatic logic [WIDTH-1:0] m_read(input int ra, input int l);
    if (RegWriteW && lane_mask_w[l] && int'(wa3w) == ra) return wd3[l];
    return mreg[ra][l];
  endfunction

  function automatic logic [WIDTH-1:0] m_imm();
    int iv;
    iv = int'(Instr >> (28 - IMMW));
    if (ImmSrcD && iv >= 2 ** (IMMW - 1)) iv = iv - 2 ** IMMW + 2 ** WIDTH;
    return WIDTH'(iv);
  endfunction

  task automatic model_reset();
    mv = 0; mrw = 0; mm2r = 0;
    mra1 = 0; mra2 = 0; mwa = 0;
    mrd1 = '0; mrd2 = '0; mimm = '0;
    for (int r = 0; r < NREGS; r++) mreg[r] = '0;
  endtask

  task automatic check_outs();
    check("out_valid", 64'(out_valid), 64'(mv));
    check("RegWriteE", 64'(RegWriteE), 64'(mrw));
    check("MemToRegE", 64'(MemToRegE), 64'(mm2r));
    if (mv) begin
      check("rd1E", 64'(rd1E), 64'(mrd1));
      check("rd2E", 64'(rd2E), 64'(mrd2));
      check("ExtImmE", 64'(ExtImmE), 64'(mimm));
      check("ra1E", 64'(ra1E), 64'(mra1));
      check("ra2E", 64'(ra2E), 64'(mra2));
      check("wa3E", 64'(wa3E), 64'(mwa));
    end
  endtask

  // One clock: check handshake outputs, let the edge happen, advance the model, check E.
  task automatic tick();
    logic st, rdy;
    int r1, r2, w;
    logic [LANES-1:0][WIDTH-1:0] n1, n2, ni;
    #1;
    r1 = m_ra1(); r2 = m_ra2(); w = fld(12);
    st  = mv && mm2r && mrw && (mwa == r1 || mwa == r2);
    rdy = !st && (!mv || out_ready);
    check("stallD", 64'(stallD), 64'(st));
    check("in_ready", 64'(in_ready), 64'(rdy));
    for (int l = 0; l < LANES; l++) begin
      n1[l] = m_read(r1, l);
      n2[l] = m_read(r2, l);
      ni[l] = m_imm();
    end
    @(posedge clk);
    #1;
    if (flushE) begin
      mv = 0; mrw = 0; mm2r = 0;
    end else if (in_valid && rdy) begin
      mv = 1; mrd1 = n1; mrd2 = n2; mimm = ni;
      mra1 = r1; mra2 = r2; mwa = w;
      mrw = RegWriteD; mm2r = MemToRegD;
    end else if (mv && out_ready) begin
      mv = 0; mrw = 0; mm2r = 0;
    end
    if (RegWriteW)
      for (int l = 0; l < LANES; l++)
        if (lane_mask_w[l]) mreg[int'(wa3w)][l] = wd3[l];
    check_outs();
  endtask

  task automatic do_reset();
    RST = 1'b0;
    #1;
    model_reset();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_RegWriteE", 64'(RegWriteE), 64'(0));
    check("rst_rd1E", 64'(rd1E), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    RST = 1'b1;
  endtask

  logic [LANES-1:0][WIDTH-1:0] snap_rd1, snap_imm;

  initial begin
    do_reset();

    // Write r3 with all lanes, then decode a read of r3.
    RegWriteW = 1; wa3w = 3; wd3 = {18'h1, 18'h2, 18'h3}; lane_mask_w = 3'b111;
    tick();
    RegWriteW = 0; in_valid = 1; Instr = 28'h0000003; RegSrc = 2'b00;
    tick();
    check("rf_write_read", 64'(rd1E), 64'({18'h1, 18'h2, 18'h3}));

    // Masked write bypassed into a same-cycle read of r5.
    RegWriteW = 1; wa3w = 5; wd3 = {3{18'h3FFFF}}; lane_mask_w = 3'b010;
    Instr = 28'h0000005;
    tick();
    check("bypass_mask", 64'(rd1E), 64'({18'h0, 18'h3FFFF, 18'h0}));
    RegWriteW = 0;

    // Immediate sign and zero extension.
    Instr = {10'h200, 18'h0}; ImmSrcD = 1;
    tick();
    check("imm_sext", 64'(ExtImmE), 64'({3{18'h3FE00}}));
    ImmSrcD = 0;
    tick();
    check("imm_zext", 64'(ExtImmE), 64'({3{18'h00200}}));

    // Load to r4 followed by a reader of r4 through ra2.
    Instr = 28'h0004021; RegWriteD = 1; MemToRegD = 1;
    tick();
    Instr = 28'h0006410; RegWriteD = 0; MemToRegD = 0;
    #1;
    check("hazard_stall", 64'(stallD), 64'(1));
    check("hazard_ready", 64'(in_ready), 64'(0));
    tick();
    check("hazard_bubble", 64'(out_valid), 64'(0));
    tick();
    check("hazard_accept", 64'(out_valid), 64'(1));
    check("hazard_ra2E", 64'(ra2E), 64'(4));

    // Backpressure hold, then flush together with a new instruction.
    Instr = {10'h155, 18'h0_1234};
    tick();
    snap_rd1 = rd1E; snap_imm = ExtImmE;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      Instr = 28'($urandom);
      tick();
      check("hold_rd1E", 64'(rd1E), 64'(snap_rd1));
      check("hold_imm", 64'(ExtImmE), 64'(snap_imm));
      check("hold_valid", 64'(out_valid), 64'(1));
    end
    out_ready = 1; flushE = 1; RegWriteD = 1;
    tick();
    check("flush_valid", 64'(out_valid), 64'(0));
    check("flush_rw", 64'(RegWriteE), 64'(0));
    flushE = 0; in_valid = 0; RegWriteD = 0;
    tick();
    check("flush_discard", 64'(out_valid), 64'(0));

    // RegSrc both set with 8 registers, then reset mid-stream.
    in_valid = 1; RegSrc = 2'b11; Instr = 28'h00000E9;
    tick();
    check("regsrc_ra1E", 64'(ra1E), 64'(7));
    check("regsrc_ra2E", 64'(ra2E), 64'(6));
    #2;
    RST = 0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'(0));
    in_valid = 0;
    do_reset();
    in_valid = 1; RegSrc = 2'b00; Instr = 28'h0000503;
    tick();
    check("rst_clears_r3", 64'(rd1E), 64'(0));
    check("rst_clears_r5", 64'(rd2E), 64'(0));

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      flushE      = ($urandom_range(0, 15) == 0);
      Instr       = 28'($urandom);
      RegSrc      = 2'($urandom);
      ImmSrcD     = 1'($urandom);
      RegWriteD   = 1'($urandom);
      MemToRegD   = 1'($urandom);
      RegWriteW   = 1'($urandom);
      wa3w        = AW'($urandom_range(0, NREGS - 1));
      lane_mask_w = LANES'($urandom);
      for (int l = 0; l < LANES; l++) wd3[l] = WIDTH'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
